// File: rtl/serial_pkg.sv
// Shared types for the bit-serial front end and the pattern detectors that consume its stream.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: a one-word holding register feeds a shift register that
// emits one bit per bit_en tick, reloading straight from hold so consecutive words have no gap.
module word_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             data_out,
  output logic             valid_out,
  output logic             word_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             word_end_q, word_end_d;

  logic             cur_bit;
  logic [WIDTH-1:0] sreg_shifted;

  assign cur_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    word_end_d   = 1'b0;

    // in_ready is only high with hold empty, so accept never collides with a load below.
    if (in_valid && in_ready) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q) begin
          sreg_d       = hold_q;
          cnt_d        = '0;
          hold_valid_d = 1'b0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_en) begin
          data_out_d  = cur_bit;
          valid_out_d = 1'b1;
          sreg_d      = sreg_shifted;
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            word_end_d = 1'b1;
            cnt_d      = '0;
            if (hold_valid_q) begin
              sreg_d       = hold_q;
              hold_valid_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sreg_q       <= '0;
      cnt_q        <= '0;
      data_out_q   <= 1'b0;
      valid_out_q  <= 1'b0;
      word_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      word_end_q   <= word_end_d;
    end
  end

  assign in_ready  = !hold_valid_q;
  assign busy      = (state_q == ST_SHIFT) || hold_valid_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign word_end  = word_end_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed and random checks of word_serializer (MSB-first and LSB-first instances) against a bit-queue model.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       bit_en = 1'b0;

  logic in_ready0, data_out0, valid_out0, word_end0, busy0;
  logic in_ready1, data_out1, valid_out1, word_end1, busy1;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .bit_en(bit_en), .data_out(data_out0), .valid_out(valid_out0), .word_end(word_end0),
    .busy(busy0)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .bit_en(bit_en), .data_out(data_out1), .valid_out(valid_out1), .word_end(word_end1),
    .busy(busy1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc;
  int first_cyc, last_cyc, we_cyc, nvalid, nwe;
  logic accepted;
  logic [15:0] bits0;
  logic [7:0]  bits1;
  // Each entry is {word_end, bit} in the order the stream must produce them.
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    first_cyc = -1; last_cyc = -1; we_cyc = -1; nvalid = 0; nwe = 0;
    bits0 = '0; bits1 = '0;
  endtask

  task automatic tick();
    logic a0, a1, be;
    logic [7:0] w;
    logic [1:0] e;
    a0 = rst && in_valid && in_ready0;
    a1 = rst && in_valid && in_ready1;
    be = bit_en;
    w  = in_data;
    @(posedge clk);
    #1;
    cyc++;
    accepted = a0;
    if (a0) for (int i = 7; i >= 0; i--) q0.push_back({i == 0, w[i]});
    if (a1) for (int i = 0; i < 8; i++) q1.push_back({i == 7, w[i]});

    if (valid_out0) begin
      chk("valid0_needs_bit_en", {31'd0, be}, 1);
      if (q0.size() == 0) chk("spurious_valid0", {31'd0, valid_out0}, 0);
      else begin
        e = q0.pop_front();
        chk("data0", {31'd0, data_out0}, {31'd0, e[0]});
        chk("word_end0", {31'd0, word_end0}, {31'd0, e[1]});
      end
      nvalid++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (word_end0) begin we_cyc = cyc; nwe++; end
      bits0 = {bits0[14:0], data_out0};
    end else if (word_end0) chk("word_end0_without_valid", {31'd0, word_end0}, 0);

    if (valid_out1) begin
      chk("valid1_needs_bit_en", {31'd0, be}, 1);
      if (q1.size() == 0) chk("spurious_valid1", {31'd0, valid_out1}, 0);
      else begin
        e = q1.pop_front();
        chk("data1", {31'd0, data_out1}, {31'd0, e[0]});
        chk("word_end1", {31'd0, word_end1}, {31'd0, e[1]});
      end
      bits1 = {bits1[6:0], data_out1};
    end
  endtask

  task automatic send(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    chk("accept_timeout", {31'd0, accepted}, 1);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clr_stats();
    // Reset held for two cycles
    run(2);
    chk("rst_valid_out", {31'd0, valid_out0}, 0);
    chk("rst_data_out", {31'd0, data_out0}, 0);
    chk("rst_word_end", {31'd0, word_end0}, 0);
    chk("rst_in_ready", {31'd0, in_ready0}, 1);
    chk("rst_busy", {31'd0, busy0}, 0);
    rst = 1'b1;
    bit_en = 1'b1;
    run(2);
    chk("idle_no_valid", {31'd0, valid_out0}, 0);

    // Single word 8'hB0 with latency
    clr_stats();
    send(8'hB0);
    run(12);
    chk("b0_nvalid", nvalid, 8);
    chk("b0_first_lat", first_cyc - acc_cyc, 2);
    chk("b0_last_lat", last_cyc - acc_cyc, 9);
    chk("b0_we_last", we_cyc, last_cyc);
    chk("b0_nwe", nwe, 1);
    chk("b0_bits", {24'd0, bits0[7:0]}, 32'hB0);
    chk("b0_idle_busy", {31'd0, busy0}, 0);

    // Back-to-back B6, D9
    clr_stats();
    send(8'hB6);
    send(8'hD9);
    chk("b2b_in_ready_low", {31'd0, in_ready0}, 0);
    chk("b2b_busy", {31'd0, busy0}, 1);
    tick();
    chk("b2b_in_ready_still_low", {31'd0, in_ready0}, 0);
    run(20);
    chk("b2b_nvalid", nvalid, 16);
    chk("b2b_contiguous", last_cyc - first_cyc, 15);
    chk("b2b_nwe", nwe, 2);
    chk("b2b_we_last", we_cyc, last_cyc);
    chk("b2b_bits", {16'd0, bits0}, 32'hB6D9);

    // bit_en on alternate clocks
    clr_stats();
    bit_en = 1'b0;
    send(8'hB0);
    for (int i = 0; i < 24; i++) begin
      bit_en = ~bit_en;
      tick();
    end
    chk("alt_nvalid", nvalid, 8);
    chk("alt_span", last_cyc - first_cyc, 14);
    chk("alt_bits", {24'd0, bits0[7:0]}, 32'hB0);

    // Asynchronous reset mid-word
    clr_stats();
    bit_en = 1'b1;
    send(8'hFF);
    for (int i = 0; i < 20 && nvalid < 3; i++) tick();
    chk("mid_nvalid", nvalid, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_valid_out", {31'd0, valid_out0}, 0);
    chk("async_in_ready", {31'd0, in_ready0}, 1);
    chk("async_busy", {31'd0, busy0}, 0);
    chk("async_data_out", {31'd0, data_out0}, 0);
    q0.delete();
    q1.delete();
    tick();
    rst = 1'b1;
    clr_stats();
    send(8'h80);
    run(12);
    chk("post_rst_nvalid", nvalid, 8);
    chk("post_rst_bits", {24'd0, bits0[7:0]}, 32'h80);

    // LSB-first instance with 8'h0D
    clr_stats();
    send(8'h0D);
    run(12);
    chk("lsb_bits", {24'd0, bits1}, 32'hB0);
    chk("lsb_msb_inst_bits", {24'd0, bits0[7:0]}, 32'h0D);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(1, 0));
      in_data  = 8'($urandom);
      bit_en   = ($urandom_range(3, 0) != 0);
      tick();
    end
    in_valid = 1'b0;
    bit_en   = 1'b1;
    for (int i = 0; i < 40 && (busy0 || busy1); i++) tick();
    tick();
    chk("drain_busy0", {31'd0, busy0}, 0);
    chk("drain_busy1", {31'd0, busy1}, 0);
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
